// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Bundles the word-side handshake and the serial-side outputs of
//   bit_serializer. W must match the W of the serializer it is bound to.
//
//   data_in      word to serialize (producer -> serializer)
//   data_valid   data_in is valid this cycle (producer -> serializer)
//   data_ready   holding register empty (serializer -> producer)
//   serial_out   serial bit stream, feeds the detector's `in`
//   serial_valid serial_out carries a data bit
//   frame_start  high during the first bit of each word
//   busy         shifter active or holding register occupied
//
//   master: the producer / observer side.
//   slave : the serializer itself.
interface bit_serializer_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial stage feeding the 1011 sequence detector.
//   A W-bit word is accepted over valid/ready into a one-word holding
//   register, then shifted out one bit per clock. A word waiting in the
//   holding register is loaded on the edge that retires the last bit of
//   the current word, so back-to-back words leave no gap. While nothing is
//   being shifted, serial_out sits at IDLE_BIT.
//
//   Parameters
//     W          word width, 2..32
//     MSB_FIRST  1: bit W-1 leaves first; 0: bit 0 leaves first
//     IDLE_BIT   level on serial_out while not shifting
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high; discards in-flight and held words
//     bus    bit_serializer_if slave modport (handshake + serial outputs)
//
//   Every output comes straight from a flop or from a function of flops;
//   data_ready has no combinational dependence on data_valid.
module bit_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  bit_serializer_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state;
  logic [W-1:0]   hold_reg;
  logic           hold_valid;
  logic [W-1:0]   shift_reg;
  logic [CW-1:0]  bit_cnt;
  logic           serial_out_r;
  logic           serial_valid_r;
  logic           frame_start_r;
  logic           accept;

  // Bit that leaves first from a given word image.
  function automatic logic lead_bit(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  // Word image after one bit has left; vacated position fills with 0.
  function automatic logic [W-1:0] advance(input logic [W-1:0] v);
    return MSB_FIRST ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  // Accept only into an empty holding register; draining needs it full,
  // so an accept and a drain never land on the same edge.
  assign accept = bus.data_valid && !hold_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold_reg       <= '0;
      hold_valid     <= 1'b0;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      serial_out_r   <= IDLE_BIT;
      serial_valid_r <= 1'b0;
      frame_start_r  <= 1'b0;
    end else begin
      if (accept) begin
        hold_reg   <= bus.data_in;
        hold_valid <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (hold_valid) begin
            shift_reg      <= hold_reg;
            hold_valid     <= 1'b0;
            bit_cnt        <= '0;
            serial_out_r   <= lead_bit(hold_reg);
            serial_valid_r <= 1'b1;
            frame_start_r  <= 1'b1;
            state          <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt == LAST) begin
            if (hold_valid) begin
              // Reload on the last-bit edge: next word starts with no bubble.
              shift_reg      <= hold_reg;
              hold_valid     <= 1'b0;
              bit_cnt        <= '0;
              serial_out_r   <= lead_bit(hold_reg);
              serial_valid_r <= 1'b1;
              frame_start_r  <= 1'b1;
            end else begin
              shift_reg      <= '0;
              bit_cnt        <= '0;
              serial_out_r   <= IDLE_BIT;
              serial_valid_r <= 1'b0;
              frame_start_r  <= 1'b0;
              state          <= IDLE;
            end
          end else begin
            // serial_out is registered, so it takes the leading bit of the
            // image that shift_reg is about to hold.
            shift_reg      <= advance(shift_reg);
            serial_out_r   <= lead_bit(advance(shift_reg));
            bit_cnt        <= bit_cnt + CW'(1);
            frame_start_r  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_ready   = !hold_valid;
  assign bus.serial_out   = serial_out_r;
  assign bus.serial_valid = serial_valid_r;
  assign bus.frame_start  = frame_start_r;
  assign bus.busy         = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   dut0: W=8, MSB first, idle level 0 -- directed scenarios plus random
//         traffic, checked every cycle against a timeline model.
//   dut1: W=4, LSB first, idle level 1 -- directed word.
//   Timeline model: a word accepted at edge k starts at edge
//   s = max(k+1, end_of_previous_word+1) and owns edges s..s+W-1; it sits
//   in the holding register for edges k..s-1.
module tb_bit_serializer;

  logic clk;
  logic reset;

  bit_serializer_if #(.W(8)) b0 ();
  bit_serializer_if #(.W(4)) b1 ();

  bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  bit_serializer #(.W(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model for dut0 ----------------
  typedef struct {
    logic [7:0] w;
    int         k;
    int         s;
  } mword_t;

  mword_t     mq[$];
  logic [7:0] sbq[$];
  mword_t     mtmp;
  int         m_n = 0;
  int         m_last_end = -1000;
  int         m_idx;
  bit         exp_ready = 1'b1;
  logic       e_so, e_sv, e_fs, e_hold;
  logic [7:0] asm_w;
  int         asm_cnt = 0;
  logic [7:0] sb_exp;

  always begin
    @(posedge clk);
    m_n++;
    if (reset) begin
      mq.delete();
      sbq.delete();
      m_last_end = -1000;
      asm_cnt    = 0;
    end else if (b0.data_valid && exp_ready) begin
      mtmp.w = b0.data_in;
      mtmp.k = m_n;
      mtmp.s = (m_n + 1 > m_last_end + 1) ? m_n + 1 : m_last_end + 1;
      m_last_end = mtmp.s + 7;
      mq.push_back(mtmp);
      sbq.push_back(b0.data_in);
    end
    #1;
    e_so = 1'b0; e_sv = 1'b0; e_fs = 1'b0; e_hold = 1'b0;
    foreach (mq[i]) begin
      if (m_n >= mq[i].s && m_n <= mq[i].s + 7) begin
        m_idx = m_n - mq[i].s;
        e_so  = mq[i].w[7 - m_idx];
        e_sv  = 1'b1;
        e_fs  = (m_idx == 0);
      end
      if (mq[i].k <= m_n && m_n < mq[i].s) e_hold = 1'b1;
    end
    exp_ready = !e_hold;
    chk("m_serial_out",   32'(b0.serial_out),   32'(e_so));
    chk("m_serial_valid", 32'(b0.serial_valid), 32'(e_sv));
    chk("m_frame_start",  32'(b0.frame_start),  32'(e_fs));
    chk("m_data_ready",   32'(b0.data_ready),   32'(!e_hold));
    chk("m_busy",         32'(b0.busy),         32'(e_hold || e_sv));
    while (mq.size() > 0 && mq[0].s + 7 < m_n) void'(mq.pop_front());

    // Reassemble words from the DUT's own serial stream.
    if (!reset && b0.serial_valid) begin
      if (b0.frame_start) asm_cnt = 0;
      asm_w = {asm_w[6:0], b0.serial_out};
      asm_cnt++;
      if (asm_cnt == 8) begin
        asm_cnt = 0;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_word", 32'(asm_w), 32'hFFFF_FFFF);
        end else begin
          sb_exp = sbq.pop_front();
          chk("sb_word", 32'(asm_w), 32'(sb_exp));
        end
      end
    end
  end

  // ---------------- recorder for the back-to-back scenario ----------------
  bit   rec_on = 1'b0;
  logic rq_so[$];
  logic rq_sv[$];
  logic rq_fs[$];

  always begin
    @(posedge clk);
    #2;
    if (rec_on) begin
      rq_so.push_back(b0.serial_out);
      rq_sv.push_back(b0.serial_valid);
      rq_fs.push_back(b0.frame_start);
    end
  end

  // Present a word on dut0 and wait for acceptance. Called at a negedge;
  // returns at the negedge after the accepting edge, data_valid still high.
  task automatic send(input logic [7:0] w);
    bit rdy;
    bit done;
    done = 1'b0;
    b0.data_in    = w;
    b0.data_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      rdy = b0.data_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      @(negedge clk);
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0]  pat2;
    logic [23:0] pat3;
    logic [3:0]  pat5;
    int          waited;

    pat2 = 8'hB0;
    pat3 = 24'hBB2DFF;
    pat5 = 4'b1101;

    reset         = 1'b1;
    b0.data_in    = '0;
    b0.data_valid = 1'b0;
    b1.data_in    = '0;
    b1.data_valid = 1'b0;
    #10;
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_serial_out",   32'(b0.serial_out),   32'd0);
      chk("idle_serial_valid", 32'(b0.serial_valid), 32'd0);
      chk("idle_data_ready",   32'(b0.data_ready),   32'd1);
      chk("idle_busy",         32'(b0.busy),         32'd0);
      chk("idle1_serial_out",  32'(b1.serial_out),   32'd1);
    end

    // LSB-first, W=4, idle level 1: 4'b1101 -> 1,0,1,1.
    b1.data_in    = 4'b1101;
    b1.data_valid = 1'b1;
    @(negedge clk);
    b1.data_valid = 1'b0;
    chk("lsb_held_idle_level", 32'(b1.serial_out), 32'd1);
    chk("lsb_held_busy",       32'(b1.busy),       32'd1);
    chk("lsb_held_ready",      32'(b1.data_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lsb_bit",   32'(b1.serial_out),   32'(pat5[i]));
      chk("lsb_valid", 32'(b1.serial_valid), 32'd1);
      chk("lsb_frame", 32'(b1.frame_start),  32'(i == 0));
    end
    @(negedge clk);
    chk("lsb_end_idle_level", 32'(b1.serial_out),   32'd1);
    chk("lsb_end_valid",      32'(b1.serial_valid), 32'd0);

    // Single word 8'hB0, MSB first.
    send(8'hB0);
    b0.data_valid = 1'b0;
    chk("b0_wait_idle_level", 32'(b0.serial_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b0_bit",   32'(b0.serial_out),   32'(pat2[7 - i]));
      chk("b0_valid", 32'(b0.serial_valid), 32'd1);
      chk("b0_frame", 32'(b0.frame_start),  32'(i == 0));
    end
    @(negedge clk);
    chk("b0_after_idle", 32'(b0.serial_out),   32'd0);
    chk("b0_after_vld",  32'(b0.serial_valid), 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back BB, 2D, FF with data_valid held high.
    rq_so.delete(); rq_sv.delete(); rq_fs.delete();
    send(8'hBB);
    rec_on = 1'b1;
    send(8'h2D);
    chk("b2b_ready_low_held", 32'(b0.data_ready), 32'd0);
    chk("b2b_busy_held",      32'(b0.busy),       32'd1);
    send(8'hFF);
    b0.data_valid = 1'b0;
    waited = 0;
    while (rq_so.size() < 24 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    rec_on = 1'b0;
    chk("b2b_bit_count", 32'(rq_so.size() >= 24), 32'd1);
    if (rq_so.size() >= 24) begin
      for (int i = 0; i < 24; i++) begin
        chk("b2b_bit",   32'(rq_so[i]), 32'(pat3[23 - i]));
        chk("b2b_valid", 32'(rq_sv[i]), 32'd1);
        chk("b2b_frame", 32'(rq_fs[i]), 32'((i % 8) == 0));
      end
    end
    repeat (4) @(negedge clk);

    // Reset at bit 3 of 8'hB5 while 8'h0F is held.
    send(8'hB5);
    send(8'h0F);
    b0.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_bit3",  32'(b0.serial_out), 32'd1);
    chk("rst_pre_held",  32'(b0.data_ready), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_serial_out",   32'(b0.serial_out),   32'd0);
    chk("rst_async_serial_valid", 32'(b0.serial_valid), 32'd0);
    chk("rst_async_frame_start",  32'(b0.frame_start),  32'd0);
    chk("rst_async_data_ready",   32'(b0.data_ready),   32'd1);
    chk("rst_async_busy",         32'(b0.busy),         32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_after_serial_out",   32'(b0.serial_out),   32'd0);
      chk("rst_after_serial_valid", 32'(b0.serial_valid), 32'd0);
    end

    // Random words with random gaps.
    for (int n = 0; n < 50; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        b0.data_valid = 1'b0;
        b0.data_in    = 8'($urandom);
        repeat (gap) @(negedge clk);
      end
      send(8'($urandom));
    end
    b0.data_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("sb_no_partial", 32'(asm_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
